multicycle_ctrl: RTL and testbench
==================================

Name: multicycle_ctrl

Overview:
- Moore-style control FSM that sequences a shared-memory multi-cycle MIPS datapath: instruction fetch, decode, execute, memory access and writeback, one step per state.
- Supports R-type, addi, slti, lw, sw and beq.
- Sits between the instruction register opcode field and the datapath mux/enable controls.
- Stalls on a memory ready handshake, traps on illegal opcodes and counts retired instructions.

Parameters:
- CNT_W, 32, width of the retired-instruction counter
- OP_W, 6, opcode width

Ports:
- clk_i  input  1  clock, rising edge
- rst_i  input  1  asynchronous reset, active-low
- run_i  input  1  level; enables fetching of new instructions
- opcode_i  input  OP_W  instruction register bits [31:26]
- mem_ready_i  input  1  memory completes the current read/write this cycle
- pc_write_o  output  1  unconditional PC load
- pc_write_cond_o  output  1  PC load if ALU zero
- iord_o  output  1  0 = PC addresses memory, 1 = ALU out
- mem_read_o  output  1  memory read request
- mem_write_o  output  1  memory write request
- ir_write_o  output  1  instruction register load
- mem_to_reg_o  output  1  1 = MDR to register file
- reg_dst_o  output  1  1 = rd, 0 = rt
- reg_write_o  output  1  register file write
- alu_src_a_o  output  1  0 = PC, 1 = rs
- alu_src_b_o  output  2  00 = rt, 01 = const 4, 10 = sign-ext imm, 11 = sign-ext imm<<2
- alu_op_o  output  3  ALU control code
- pc_source_o  output  2  00 = ALU result, 01 = ALUOut
- illegal_o  output  1  trap flag
- state_o  output  4  current state
- retired_o  output  CNT_W  retired-instruction count

Behaviour:
- Reset (rst_i low, asynchronous):
  - State is IDLE, retired_o is 0.
  - All control outputs are 0: alu_src_b 00, alu_op 000, pc_source 00.
- Outputs decode from state only, except ir_write_o and pc_write_o in FETCH, and mem_read_o/mem_write_o are gated as listed per state.
- Any control output not listed for a state is 0.
- ALU op codes: R-type 010, addi 110, slti 111, lw/sw/address/PC+4 000, beq 001.
- States (state_o encoding) and transitions:
  - IDLE(0): goes to FETCH when run_i=1.
  - FETCH(1): mem_read=1, iord=0, src_a=0, src_b=01, alu_op=000, pc_source=00. ir_write and pc_write are asserted only in the cycle mem_ready_i=1; that cycle goes to DECODE, otherwise stays in FETCH.
  - DECODE(2): src_a=0, src_b=11, alu_op=000 (branch target into ALUOut). Next state by opcode:
    - 000000 goes to EXEC.
    - 001000 or 001010 goes to IMM_EXEC.
    - 100011 or 101011 goes to MEM_ADDR.
    - 000100 goes to BRANCH.
    - Any other opcode goes to TRAP.
  - MEM_ADDR(3): src_a=1, src_b=10, alu_op=000. Goes to MEM_RD for lw, MEM_WR for sw. The opcode is re-sampled here; the IR is stable.
  - MEM_RD(4): mem_read=1, iord=1. Goes to MEM_WB when mem_ready_i=1, otherwise waits.
  - MEM_WB(5): reg_write=1, mem_to_reg=1, reg_dst=0. Retires.
  - MEM_WR(6): mem_write=1, iord=1. Retires in the cycle mem_ready_i=1, otherwise waits.
  - EXEC(7): src_a=1, src_b=00, alu_op=010. Goes to R_WB.
  - R_WB(8): reg_write=1, reg_dst=1. Retires.
  - IMM_EXEC(9): src_a=1, src_b=10, alu_op=110 for addi, 111 for slti. Goes to IMM_WB.
  - IMM_WB(10): reg_write=1, reg_dst=0. Retires.
  - BRANCH(11): src_a=1, src_b=00, alu_op=001, pc_write_cond=1, pc_source=01. Retires.
  - TRAP(12): illegal_o=1, all other controls 0. Held until reset; not retired.
- Retire:
  - retired_o increments by 1 on the leaving edge, wrapping modulo 2^CNT_W.
  - Next state is FETCH if run_i=1, else IDLE.
- Deasserting run_i mid-instruction has no effect until the retire boundary.
- Minimum latencies with mem_ready_i tied high:
  - beq: 3 cycles
  - R-type, addi, slti, sw: 4 cycles
  - lw: 5 cycles
  - Each memory wait cycle adds 1.
- Unused state codes 13-15 go to TRAP.
- Reset mid-instruction aborts immediately; there is no partial writeback after reset release.

Decomposition:
- Shared package holds:
  - opcode constants: OP_RTYPE, OP_ADDI, OP_SLTI, OP_LW, OP_SW, OP_BEQ
  - ALU op codes: ALU_ADD=000, ALU_SUB=001, ALU_R=010, ALU_ADDI=110, ALU_SLTI=111
  - state encoding constants
  - alu_src_b / pc_source select codes
- One natural sub-module: multicycle_ctrl_outdec, a pure combinational state-to-controls decoder. The FSM, counter and handshake stay in the top module.

Test Plan:
- Reset:
  - rst_i low with run_i=1 -> state_o=0, all controls 0, retired_o=0.
  - Release reset -> FETCH on the next edge with mem_read_o=1.
- R-type, mem_ready_i high:
  - opcode 000000 -> states 1,2,7,8.
  - alu_op_o=010 in EXEC; reg_write_o=1 and reg_dst_o=1 in R_WB.
  - retired_o=1 after 4 cycles.
- lw with two memory wait cycles in MEM_RD:
  - opcode 100011 -> 7 cycles total, mem_to_reg_o=1 in MEM_WB.
  - ir_write_o pulses exactly once, in the FETCH ready cycle.
- beq:
  - opcode 000100 -> 3 cycles.
  - In BRANCH: pc_write_cond_o=1, pc_source_o=01, alu_op_o=001.
- Illegal opcode:
  - opcode 111111 -> DECODE then TRAP, illegal_o=1 held 20 cycles, retired_o unchanged.
  - Reset pulse -> IDLE.
- run_i and reset mid-operation:
  - Drop run_i during EXEC of addi -> completes IMM_WB, then IDLE; retired_o +1.
  - Separately, assert rst_i low during MEM_WR -> outputs 0 immediately, no mem_write_o after release.

Source files
------------

// File: rtl/multicycle_ctrl_pkg.sv
// multicycle_ctrl_pkg: shared opcodes, ALU codes, select codes, state encoding and control bundle
package multicycle_ctrl_pkg;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_R    = 3'b010;
  localparam logic [2:0] ALU_ADDI = 3'b110;
  localparam logic [2:0] ALU_SLTI = 3'b111;
  localparam logic [1:0] SRCB_RT      = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEM_ADDR = 4'd3,
    S_MEM_RD   = 4'd4,
    S_MEM_WB   = 4'd5,
    S_MEM_WR   = 4'd6,
    S_EXEC     = 4'd7,
    S_R_WB     = 4'd8,
    S_IMM_EXEC = 4'd9,
    S_IMM_WB   = 4'd10,
    S_BRANCH   = 4'd11,
    S_TRAP     = 4'd12
  } state_t;
  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic [1:0] pc_source;
    logic       illegal;
  } ctrl_t;
  // Opcode dispatch out of DECODE; anything unsupported traps.
  function automatic state_t decode_next(input logic [5:0] op);
    case (op)
      OP_RTYPE:        return S_EXEC;
      OP_ADDI, OP_SLTI: return S_IMM_EXEC;
      OP_LW, OP_SW:    return S_MEM_ADDR;
      OP_BEQ:          return S_BRANCH;
      default:         return S_TRAP;
    endcase
  endfunction
endpackage

// File: rtl/multicycle_ctrl_if.sv
// multicycle_ctrl_if: datapath-facing bundle between controller (master) and datapath (slave)
interface multicycle_ctrl_if #(
  parameter int CNT_W = 32,
  parameter int OP_W  = 6
);
  logic             run_i;
  logic [OP_W-1:0]  opcode_i;
  logic             mem_ready_i;
  logic             pc_write_o;
  logic             pc_write_cond_o;
  logic             iord_o;
  logic             mem_read_o;
  logic             mem_write_o;
  logic             ir_write_o;
  logic             mem_to_reg_o;
  logic             reg_dst_o;
  logic             reg_write_o;
  logic             alu_src_a_o;
  logic [1:0]       alu_src_b_o;
  logic [2:0]       alu_op_o;
  logic [1:0]       pc_source_o;
  logic             illegal_o;
  logic [3:0]       state_o;
  logic [CNT_W-1:0] retired_o;
  modport master (
    input  run_i, opcode_i, mem_ready_i,
    output pc_write_o, pc_write_cond_o, iord_o, mem_read_o, mem_write_o, ir_write_o,
           mem_to_reg_o, reg_dst_o, reg_write_o, alu_src_a_o, alu_src_b_o, alu_op_o,
           pc_source_o, illegal_o, state_o, retired_o
  );
  modport slave (
    output run_i, opcode_i, mem_ready_i,
    input  pc_write_o, pc_write_cond_o, iord_o, mem_read_o, mem_write_o, ir_write_o,
           mem_to_reg_o, reg_dst_o, reg_write_o, alu_src_a_o, alu_src_b_o, alu_op_o,
           pc_source_o, illegal_o, state_o, retired_o
  );
endinterface

// File: rtl/multicycle_ctrl_outdec.sv
// multicycle_ctrl_outdec: combinational state-to-datapath-controls decoder
module multicycle_ctrl_outdec
  import multicycle_ctrl_pkg::*;
#(
  parameter int OP_W = 6
) (
  input  state_t          state_i,
  input  logic [OP_W-1:0] opcode_i,
  input  logic            mem_ready_i,
  output ctrl_t           ctrl_o
);
  // Moore decode; only the FETCH IR/PC loads wait on the memory handshake.
  always_comb begin
    ctrl_o = '0;
    case (state_i)
      S_FETCH: begin
        ctrl_o.mem_read  = 1'b1;
        ctrl_o.alu_src_b = SRCB_FOUR;
        ctrl_o.alu_op    = ALU_ADD;
        ctrl_o.pc_source = PCSRC_ALU;
        ctrl_o.ir_write  = mem_ready_i;
        ctrl_o.pc_write  = mem_ready_i;
      end
      S_DECODE: begin
        ctrl_o.alu_src_b = SRCB_IMM_SH2;
        ctrl_o.alu_op    = ALU_ADD;
      end
      S_MEM_ADDR: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_IMM;
        ctrl_o.alu_op    = ALU_ADD;
      end
      S_MEM_RD: begin
        ctrl_o.mem_read = 1'b1;
        ctrl_o.iord     = 1'b1;
      end
      S_MEM_WB: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.mem_to_reg = 1'b1;
      end
      S_MEM_WR: begin
        ctrl_o.mem_write = 1'b1;
        ctrl_o.iord      = 1'b1;
      end
      S_EXEC: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_RT;
        ctrl_o.alu_op    = ALU_R;
      end
      S_R_WB: begin
        ctrl_o.reg_write = 1'b1;
        ctrl_o.reg_dst   = 1'b1;
      end
      S_IMM_EXEC: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_IMM;
        ctrl_o.alu_op    = (opcode_i == OP_SLTI) ? ALU_SLTI : ALU_ADDI;
      end
      S_IMM_WB: ctrl_o.reg_write = 1'b1;
      S_BRANCH: begin
        ctrl_o.alu_src_a     = 1'b1;
        ctrl_o.alu_src_b     = SRCB_RT;
        ctrl_o.alu_op        = ALU_SUB;
        ctrl_o.pc_write_cond = 1'b1;
        ctrl_o.pc_source     = PCSRC_ALUOUT;
      end
      S_TRAP: ctrl_o.illegal = 1'b1;
      default: ;
    endcase
  end
endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multi-cycle MIPS control FSM with memory stall, trap and retire counter
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int CNT_W = 32,
  parameter int OP_W  = 6
) (
  input  logic               clk_i,
  input  logic               rst_i,
  multicycle_ctrl_if.master  bus
);
  state_t           state_q, state_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             retire;
  ctrl_t            ctrl;
  // Next state; every retiring state hands over to FETCH or IDLE depending on run.
  always_comb begin
    state_d = state_q;
    retire  = (state_q == S_MEM_WB) || (state_q == S_R_WB) || (state_q == S_IMM_WB) ||
              (state_q == S_BRANCH) || (state_q == S_MEM_WR && bus.mem_ready_i);
    case (state_q)
      S_IDLE:     state_d = bus.run_i ? S_FETCH : S_IDLE;
      S_FETCH:    state_d = bus.mem_ready_i ? S_DECODE : S_FETCH;
      S_DECODE:   state_d = decode_next(bus.opcode_i);
      S_MEM_ADDR: state_d = (bus.opcode_i == OP_SW) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:   state_d = bus.mem_ready_i ? S_MEM_WB : S_MEM_RD;
      S_EXEC:     state_d = S_R_WB;
      S_IMM_EXEC: state_d = S_IMM_WB;
      S_MEM_WB, S_MEM_WR, S_R_WB, S_IMM_WB, S_BRANCH, S_TRAP: state_d = state_q;
      default:    state_d = S_TRAP;
    endcase
    if (retire) state_d = bus.run_i ? S_FETCH : S_IDLE;
    retired_d = retired_q + CNT_W'(retire);
  end
  // State and retire counter; reset aborts any instruction in flight.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q   <= S_IDLE;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      retired_q <= retired_d;
    end
  end
  multicycle_ctrl_outdec #(.OP_W(OP_W)) u_outdec (
    .state_i     (state_q),
    .opcode_i    (bus.opcode_i),
    .mem_ready_i (bus.mem_ready_i),
    .ctrl_o      (ctrl)
  );
  assign bus.pc_write_o      = ctrl.pc_write;
  assign bus.pc_write_cond_o = ctrl.pc_write_cond;
  assign bus.iord_o          = ctrl.iord;
  assign bus.mem_read_o      = ctrl.mem_read;
  assign bus.mem_write_o     = ctrl.mem_write;
  assign bus.ir_write_o      = ctrl.ir_write;
  assign bus.mem_to_reg_o    = ctrl.mem_to_reg;
  assign bus.reg_dst_o       = ctrl.reg_dst;
  assign bus.reg_write_o     = ctrl.reg_write;
  assign bus.alu_src_a_o     = ctrl.alu_src_a;
  assign bus.alu_src_b_o     = ctrl.alu_src_b;
  assign bus.alu_op_o        = ctrl.alu_op;
  assign bus.pc_source_o     = ctrl.pc_source;
  assign bus.illegal_o       = ctrl.illegal;
  assign bus.state_o         = state_q;
  assign bus.retired_o       = retired_q;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: directed self-checking bench for the multi-cycle control FSM
module tb_multicycle_ctrl;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   irw_cnt = 0;
  multicycle_ctrl_if #(.CNT_W(32), .OP_W(6)) bus ();
  multicycle_ctrl #(.CNT_W(32), .OP_W(6)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );
  always #5 clk = ~clk;
  always @(negedge clk) if (bus.ir_write_o) irw_cnt++;
  logic [16:0] ctl;
  assign ctl = {bus.pc_write_o, bus.pc_write_cond_o, bus.iord_o, bus.mem_read_o, bus.mem_write_o,
                bus.ir_write_o, bus.mem_to_reg_o, bus.reg_dst_o, bus.reg_write_o, bus.alu_src_a_o,
                bus.alu_src_b_o, bus.alu_op_o, bus.pc_source_o, bus.illegal_o};
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    rst = 1'b0;
    bus.run_i = 1'b1;
    bus.opcode_i = 6'b000000;
    bus.mem_ready_i = 1'b1;
    #12;
    chk("rst_state", bus.state_o, 0);
    chk("rst_ctl", ctl, 0);
    chk("rst_retired", bus.retired_o, 0);
    rst = 1'b1;
    tick();
    chk("rt_fetch_state", bus.state_o, 1);
    chk("rt_fetch_memrd", bus.mem_read_o, 1);
    chk("rt_fetch_irw", bus.ir_write_o, 1);
    chk("rt_fetch_pcw", bus.pc_write_o, 1);
    chk("rt_fetch_srcb", bus.alu_src_b_o, 2'b01);
    tick();
    chk("rt_decode_state", bus.state_o, 2);
    chk("rt_decode_srcb", bus.alu_src_b_o, 2'b11);
    chk("rt_decode_srca", bus.alu_src_a_o, 0);
    tick();
    chk("rt_exec_state", bus.state_o, 7);
    chk("rt_exec_aluop", bus.alu_op_o, 3'b010);
    chk("rt_exec_srca", bus.alu_src_a_o, 1);
    tick();
    chk("rt_rwb_state", bus.state_o, 8);
    chk("rt_rwb_regw", bus.reg_write_o, 1);
    chk("rt_rwb_regdst", bus.reg_dst_o, 1);
    chk("rt_rwb_retired", bus.retired_o, 0);
    bus.opcode_i = 6'b100011;
    tick();
    chk("rt_done_state", bus.state_o, 1);
    chk("rt_done_retired", bus.retired_o, 1);
    irw_cnt = 0;
    tick();
    chk("lw_decode_state", bus.state_o, 2);
    tick();
    chk("lw_addr_state", bus.state_o, 3);
    chk("lw_addr_srcb", bus.alu_src_b_o, 2'b10);
    tick();
    bus.mem_ready_i = 1'b0;
    chk("lw_rd_state", bus.state_o, 4);
    chk("lw_rd_iord", bus.iord_o, 1);
    chk("lw_rd_memrd", bus.mem_read_o, 1);
    tick();
    chk("lw_wait1_state", bus.state_o, 4);
    tick();
    chk("lw_wait2_state", bus.state_o, 4);
    bus.mem_ready_i = 1'b1;
    tick();
    chk("lw_wb_state", bus.state_o, 5);
    chk("lw_wb_memtoreg", bus.mem_to_reg_o, 1);
    chk("lw_wb_regw", bus.reg_write_o, 1);
    chk("lw_wb_regdst", bus.reg_dst_o, 0);
    bus.opcode_i = 6'b000100;
    tick();
    chk("lw_done_state", bus.state_o, 1);
    chk("lw_done_retired", bus.retired_o, 2);
    chk("lw_irw_once", irw_cnt, 1);
    tick();
    chk("beq_decode_state", bus.state_o, 2);
    tick();
    chk("beq_br_state", bus.state_o, 11);
    chk("beq_br_pwc", bus.pc_write_cond_o, 1);
    chk("beq_br_pcsrc", bus.pc_source_o, 2'b01);
    chk("beq_br_aluop", bus.alu_op_o, 3'b001);
    bus.opcode_i = 6'b111111;
    tick();
    chk("beq_done_state", bus.state_o, 1);
    chk("beq_done_retired", bus.retired_o, 3);
    tick();
    chk("ill_decode_state", bus.state_o, 2);
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("ill_trap_state", bus.state_o, 12);
      chk("ill_trap_flag", bus.illegal_o, 1);
    end
    chk("ill_trap_ctl", ctl, 17'h1);
    chk("ill_trap_retired", bus.retired_o, 3);
    rst = 1'b0;
    #1;
    chk("ill_rst_state", bus.state_o, 0);
    chk("ill_rst_flag", bus.illegal_o, 0);
    chk("ill_rst_retired", bus.retired_o, 0);
    rst = 1'b1;
    bus.opcode_i = 6'b001000;
    tick();
    chk("addi_fetch_state", bus.state_o, 1);
    tick();
    chk("addi_decode_state", bus.state_o, 2);
    tick();
    chk("addi_exec_state", bus.state_o, 9);
    chk("addi_exec_aluop", bus.alu_op_o, 3'b110);
    chk("addi_exec_srcb", bus.alu_src_b_o, 2'b10);
    bus.run_i = 1'b0;
    tick();
    chk("addi_wb_state", bus.state_o, 10);
    chk("addi_wb_regw", bus.reg_write_o, 1);
    chk("addi_wb_regdst", bus.reg_dst_o, 0);
    tick();
    chk("addi_idle_state", bus.state_o, 0);
    chk("addi_idle_retired", bus.retired_o, 1);
    tick();
    chk("addi_idle_hold", bus.state_o, 0);
    bus.run_i = 1'b1;
    bus.opcode_i = 6'b001010;
    tick();
    tick();
    tick();
    chk("slti_exec_state", bus.state_o, 9);
    chk("slti_exec_aluop", bus.alu_op_o, 3'b111);
    bus.run_i = 1'b0;
    tick();
    tick();
    chk("slti_idle_state", bus.state_o, 0);
    chk("slti_retired", bus.retired_o, 2);
    bus.run_i = 1'b1;
    bus.opcode_i = 6'b101011;
    tick();
    tick();
    tick();
    chk("sw_addr_state", bus.state_o, 3);
    bus.mem_ready_i = 1'b0;
    tick();
    chk("sw_wr_state", bus.state_o, 6);
    chk("sw_wr_memw", bus.mem_write_o, 1);
    chk("sw_wr_iord", bus.iord_o, 1);
    #2;
    rst = 1'b0;
    #1;
    chk("sw_rst_state", bus.state_o, 0);
    chk("sw_rst_ctl", ctl, 0);
    chk("sw_rst_retired", bus.retired_o, 0);
    bus.run_i = 1'b0;
    bus.mem_ready_i = 1'b1;
    #1;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("sw_post_memw", bus.mem_write_o, 0);
      chk("sw_post_state", bus.state_o, 0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
